spe_accumulator: RTL

//  Summing PE: receiving end of the PPE partial-sum stream. Each of NUM_PPE PPEs sends, in

---
 rtl/spe_accumulator.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spe_accumulator.sv
// -----------------------------------------------------------------------------
// spe_accumulator
//   Summing PE at the receiving end of the PPE partial-sum stream. Each of
//   NUM_PPE sources sends, in order, one row partial sum per output pixel owned
//   by this SPE. Arrivals from different sources interleave freely, so they are
//   re-aligned in a small reorder store indexed by each source's own sequence
//   count. Once the oldest pixel has all NUM_PPE contributions, its total is
//   added to the pixel's membrane potential. The result is thresholded, and one
//   spike packet is sent towards OMEM.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   in_valid     depacketized input packet valid
//   in_ready     input packet accepted on in_valid && in_ready
//   in_opcode    PPE_BASE..PPE_BASE+NUM_PPE-1: partial sum, 15: TIMESTEP_DONE
//   in_data      [13:0] signed partial sum, upper bits ignored
//   out_valid    spike packet valid (held until out_ready)
//   out_ready    packetizer accepts on out_valid && out_ready
//   out_dest     OMEM_ID
//   out_opcode   SPE_ID
//   out_data     {15'b0, ts[1:0], pix[6:0], spike}
//   err_drop     one-cycle pulse: unknown opcode dropped, or pixel index overflow
// -----------------------------------------------------------------------------
module spe_accumulator #(
  parameter int SPE_ID    = 0,
  parameter int NUM_PPE   = 5,
  parameter int PPE_BASE  = 0,
  parameter int NUM_SLOTS = 8,
  parameter int NUM_PIX   = 105,
  parameter int THRESHOLD = 64,
  parameter int OMEM_ID   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [24:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_dest,
  output logic [3:0]  out_opcode,
  output logic [24:0] out_data,
  output logic        err_drop
);

  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int SRC_W = (NUM_PPE > 1) ? $clog2(NUM_PPE) : 1;
  localparam logic [3:0]         OP_DONE = 4'd15;
  localparam logic signed [16:0] THRESH  = 17'(THRESHOLD);
  localparam logic signed [16:0] SAT_MAX = 17'sh0FFFF;
  localparam logic signed [16:0] SAT_MIN = 17'sh10000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_e;

  // Reorder store, per-source write pointers, and pixel/timestep bookkeeping.
  logic [NUM_PPE-1:0] mask_q    [NUM_SLOTS];
  logic [NUM_PPE-1:0] mask_d    [NUM_SLOTS];
  logic [16:0]        sum_q     [NUM_SLOTS];
  logic [16:0]        sum_d     [NUM_SLOTS];
  logic [PTR_W-1:0]   src_ptr_q [NUM_PPE];
  logic [PTR_W-1:0]   src_ptr_d [NUM_PPE];
  logic [16:0]        vmem_q    [NUM_PIX];
  logic [16:0]        vmem_d    [NUM_PIX];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [6:0]         pix_q, pix_d;
  logic [1:0]         ts_q, ts_d;
  state_e             state_q, state_d;

  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_dest_q, out_dest_d;
  logic [3:0]  out_opcode_q, out_opcode_d;
  logic [24:0] out_data_q, out_data_d;
  logic        err_drop_q, err_drop_d;

  // Decode and datapath helpers.
  logic [4:0]       src_off_s;
  logic             is_ps_s;
  logic             is_done_s;
  logic [SRC_W-1:0] src_s;
  logic [PTR_W-1:0] wr_slot_s;
  logic             all_clear_s;
  logic             head_full_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [6:0]       eff_pix_s;
  logic [16:0]      vm_s;
  logic [17:0]      tot_wide_s;
  logic [16:0]      tot_s;
  logic             spike_s;
  logic             unused_in_data_s;

  assign unused_in_data_s = ^in_data[24:14];

  // Pointer advance with wrap at NUM_SLOTS (works for non-power-of-two depths).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_W'(NUM_SLOTS - 1)) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  // Input decode, ready generation and the COMPUTE-stage arithmetic.
  always_comb begin
    // Opcodes below PPE_BASE wrap to a large offset and so fall out of range.
    src_off_s = {1'b0, in_opcode} - 5'(PPE_BASE);
    is_ps_s   = (src_off_s < 5'(NUM_PPE));
    is_done_s = (in_opcode == OP_DONE) && !is_ps_s;
    src_s     = src_off_s[SRC_W-1:0];
    if (is_ps_s) begin
      wr_slot_s = src_ptr_q[src_s];
    end else begin
      wr_slot_s = '0;
    end

    all_clear_s = 1'b1;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (mask_q[k] != '0) begin
        all_clear_s = 1'b0;
      end else begin
        all_clear_s = all_clear_s;
      end
    end
    head_full_s = &mask_q[head_q];

    if (is_ps_s) begin
      in_ready_s = !mask_q[wr_slot_s][src_s];
    end else if (is_done_s) begin
      in_ready_s = (state_q == IDLE) && all_clear_s;
    end else begin
      in_ready_s = 1'b1;
    end
    accept_s = in_valid && in_ready_s;

    // An out-of-range pixel index is folded back to pixel 0.
    if (pix_q == 7'(NUM_PIX)) begin
      eff_pix_s = 7'd0;
    end else begin
      eff_pix_s = pix_q;
    end
    vm_s       = vmem_q[eff_pix_s];
    tot_wide_s = {vm_s[16], vm_s} + {sum_q[head_q][16], sum_q[head_q]};
    if (tot_wide_s[17] != tot_wide_s[16]) begin
      if (tot_wide_s[17]) begin
        tot_s = SAT_MIN;
      end else begin
        tot_s = SAT_MAX;
      end
    end else begin
      tot_s = tot_wide_s[16:0];
    end
    spike_s = ($signed(tot_s) >= THRESH);
  end

  assign in_ready = in_ready_s;

  // Next-state logic: FSM, reorder-store updates, membrane update, outputs.
  always_comb begin
    mask_d       = mask_q;
    sum_d        = sum_q;
    src_ptr_d    = src_ptr_q;
    vmem_d       = vmem_q;
    head_d       = head_q;
    pix_d        = pix_q;
    ts_d         = ts_q;
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_dest_d   = out_dest_q;
    out_opcode_d = out_opcode_q;
    out_data_d   = out_data_q;
    err_drop_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (head_full_s) begin
          state_d = COMPUTE;
        end else begin
          state_d = IDLE;
        end
      end
      COMPUTE: begin
        if (spike_s) begin
          vmem_d[eff_pix_s] = 17'd0;
        end else begin
          vmem_d[eff_pix_s] = tot_s;
        end
        out_valid_d  = 1'b1;
        out_dest_d   = 4'(OMEM_ID);
        out_opcode_d = 4'(SPE_ID);
        out_data_d   = {15'd0, ts_q, eff_pix_s, spike_s};
        mask_d[head_q] = '0;
        sum_d[head_q]  = 17'd0;
        head_d = ptr_inc(head_q);
        pix_d  = eff_pix_s + 7'd1;
        if (pix_q == 7'(NUM_PIX)) begin
          err_drop_d = 1'b1;
        end else begin
          err_drop_d = 1'b0;
        end
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    // Accepted packets; a partial sum never targets the head slot while it is
    // full, so this cannot collide with the COMPUTE clear above.
    if (accept_s) begin
      if (is_ps_s) begin
        sum_d[wr_slot_s] = sum_q[wr_slot_s] + {{3{in_data[13]}}, in_data[13:0]};
        mask_d[wr_slot_s][src_s] = 1'b1;
        src_ptr_d[src_s] = ptr_inc(src_ptr_q[src_s]);
      end else if (is_done_s) begin
        pix_d = 7'd0;
        if (ts_q == 2'd3) begin
          ts_d = 2'd3;
        end else begin
          ts_d = ts_q + 2'd1;
        end
      end else begin
        err_drop_d = 1'b1;
      end
    end else begin
      err_drop_d = err_drop_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        mask_q[k] <= '0;
        sum_q[k]  <= 17'd0;
      end
      for (int j = 0; j < NUM_PPE; j++) begin
        src_ptr_q[j] <= '0;
      end
      for (int p = 0; p < NUM_PIX; p++) begin
        vmem_q[p] <= 17'd0;
      end
      head_q       <= '0;
      pix_q        <= 7'd0;
      ts_q         <= 2'd1;
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_dest_q   <= 4'd0;
      out_opcode_q <= 4'd0;
      out_data_q   <= 25'd0;
      err_drop_q   <= 1'b0;
    end else begin
      mask_q       <= mask_d;
      sum_q        <= sum_d;
      src_ptr_q    <= src_ptr_d;
      vmem_q       <= vmem_d;
      head_q       <= head_d;
      pix_q        <= pix_d;
      ts_q         <= ts_d;
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_dest_q   <= out_dest_d;
      out_opcode_q <= out_opcode_d;
      out_data_q   <= out_data_d;
      err_drop_q   <= err_drop_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_dest   = out_dest_q;
  assign out_opcode = out_opcode_q;
  assign out_data   = out_data_q;
  assign err_drop   = err_drop_q;

endmodule
